// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB,
// decodes op/funct into ALU and datapath controls, handles wait states and overflow.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    input  logic       zero,
    input  logic       ovf,
    output logic [2:0] ALUctr,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       illegal,
    output logic       ov_trap
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_RTYPE, C_IMM, C_LW, C_SW, C_BEQ, C_J, C_ILL} iclass_t;

    state_t     state, next;
    iclass_t    cls;
    logic [2:0] dec_alu;
    logic       dec_src, dec_ext;
    logic       ovf_q;

    always_comb begin
        cls     = C_ILL;
        dec_alu = '0;
        dec_src = 1'b0;
        dec_ext = 1'b0;
        case (op)
            6'b000000: begin
                cls = C_RTYPE;
                case (funct)
                    6'b100001: dec_alu = 3'b000;
                    6'b100000: dec_alu = 3'b001;
                    6'b100011: dec_alu = 3'b100;
                    6'b100010: dec_alu = 3'b101;
                    6'b101011: dec_alu = 3'b110;
                    6'b101010: dec_alu = 3'b111;
                    6'b100101: dec_alu = 3'b010;
                    default:   cls = C_ILL;
                endcase
            end
            6'b001001: begin cls = C_IMM; dec_alu = 3'b000; dec_src = 1'b1; dec_ext = 1'b1; end
            6'b001101: begin cls = C_IMM; dec_alu = 3'b010; dec_src = 1'b1; dec_ext = 1'b0; end
            6'b100011: begin cls = C_LW;  dec_alu = 3'b000; dec_src = 1'b1; dec_ext = 1'b1; end
            6'b101011: begin cls = C_SW;  dec_alu = 3'b000; dec_src = 1'b1; dec_ext = 1'b1; end
            6'b000100: begin cls = C_BEQ; dec_alu = 3'b100; dec_src = 1'b0; dec_ext = 1'b1; end
            6'b000010: cls = C_J;
            default:   cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
            ovf_q <= 1'b0;
        end else begin
            state <= next;
            // only add/sub report overflow; everything else must clear the flag
            if (state == S_EXE)
                ovf_q <= (dec_alu == 3'b001 || dec_alu == 3'b101) ? ovf : 1'b0;
        end
    end

    always_comb begin
        next     = state;
        ALUctr   = '0;
        ALUSrc   = 1'b0;
        ExtOp    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        PCSrc    = 2'b00;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        illegal  = 1'b0;
        ov_trap  = 1'b0;
        if (!rst) begin
            if (state != S_IF && cls != C_ILL && cls != C_J) begin
                ALUctr   = dec_alu;
                ALUSrc   = dec_src;
                ExtOp    = dec_ext;
                RegDst   = (cls == C_RTYPE);
                MemtoReg = (cls == C_LW);
            end
            case (state)
                S_IF: begin
                    MemRd = 1'b1;
                    if (imem_rdy) begin
                        IRWr = 1'b1;
                        PCWr = 1'b1;
                        next = S_ID;
                    end
                end
                S_ID: begin
                    if (cls == C_J) begin
                        PCWr  = 1'b1;
                        PCSrc = 2'b10;
                        next  = S_IF;
                    end else if (cls == C_ILL) begin
                        illegal = 1'b1;
                        next    = S_IF;
                    end else begin
                        next = S_EXE;
                    end
                end
                S_EXE: begin
                    if (cls == C_BEQ) begin
                        if (zero) begin
                            PCWr  = 1'b1;
                            PCSrc = 2'b01;
                        end
                        next = S_IF;
                    end else if (cls == C_LW || cls == C_SW) begin
                        next = S_MEM;
                    end else begin
                        next = S_WB;
                    end
                end
                S_MEM: begin
                    MemRd = (cls == C_LW);
                    MemWr = (cls == C_SW);
                    if (dmem_rdy)
                        next = (cls == C_LW) ? S_WB : S_IF;
                end
                S_WB: begin
                    RegWr   = ~ovf_q;
                    ov_trap = ovf_q;
                    next    = S_IF;
                end
                default: next = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle queues its expected control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_ctrl;

    typedef enum logic [2:0] {K_R, K_IMM, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    // strobe field order: PCWr IRWr RegWr MemRd MemWr illegal ov_trap
    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] FETCH = 7'b1101000;
    localparam logic [6:0] MRD   = 7'b0001000;
    localparam logic [6:0] MWR   = 7'b0000100;
    localparam logic [6:0] PCW   = 7'b1000000;
    localparam logic [6:0] ILLG  = 7'b0000010;
    localparam logic [6:0] RWR   = 7'b0010000;
    localparam logic [6:0] OVT   = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst, imem_rdy, dmem_rdy, zero, ovf;
    logic [5:0] op, funct;
    logic [2:0] ALUctr;
    logic       ALUSrc, ExtOp, RegDst, MemtoReg;
    logic [1:0] PCSrc;
    logic       PCWr, IRWr, RegWr, MemRd, MemWr, illegal, ov_trap;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .zero(zero), .ovf(ovf),
        .ALUctr(ALUctr), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCWr(PCWr), .IRWr(IRWr),
        .RegWr(RegWr), .MemRd(MemRd), .MemWr(MemWr), .illegal(illegal),
        .ov_trap(ov_trap)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [6:0] fld, input logic [1:0] pcs, input logic [6:0] stb);
        return {fld, pcs, stb};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_val(tag_q.pop_front(),
                      {16'h0, ALUctr, ALUSrc, ExtOp, RegDst, MemtoReg, PCSrc,
                       PCWr, IRWr, RegWr, MemRd, MemWr, illegal, ov_trap},
                      {16'h0, exp_q.pop_front()});
            check_val("alu_not_011", {31'h0, ALUctr == 3'b011}, 32'h0);
        end
    end

    task automatic step(input string t, input logic r, ir, dr, z, o, input logic [15:0] ex);
        rst = r; imem_rdy = ir; dmem_rdy = dr; zero = z; ovf = o;
        exp_q.push_back(ex);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // field order: ALUctr ALUSrc ExtOp RegDst (MemtoReg derived from kind)
    task automatic run_instr(input string t, input logic [5:0] o, f, input kind_t k,
                             input logic [2:0] a, input logic s, e, rd,
                             input int unsigned iw, dw, input logic z, ov);
        logic [6:0] fld;
        logic       ovq;
        fld = {a, s, e, rd, k == K_LW};
        op = o; funct = f;
        for (int unsigned i = 0; i < iw; i++)
            step({t, ".if_wait"}, 0, 0, 0, 0, 0, mk('0, 2'b00, MRD));
        step({t, ".if"}, 0, 1, 0, 0, 0, mk('0, 2'b00, FETCH));
        if (k == K_J) begin
            step({t, ".id_jump"}, 0, 0, 0, 0, 0, mk('0, 2'b10, PCW));
            return;
        end
        if (k == K_ILL) begin
            step({t, ".id_illegal"}, 0, 0, 0, 0, 0, mk('0, 2'b00, ILLG));
            return;
        end
        step({t, ".id"}, 0, 0, 0, 0, 0, mk(fld, 2'b00, NONE));
        if (k == K_BEQ && z)
            step({t, ".exe_taken"}, 0, 0, 0, z, ov, mk(fld, 2'b01, PCW));
        else
            step({t, ".exe"}, 0, 0, 0, z, ov, mk(fld, 2'b00, NONE));
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            for (int unsigned i = 0; i < dw; i++)
                step({t, ".mem_wait"}, 0, 0, 0, 0, 0, mk(fld, 2'b00, k == K_LW ? MRD : MWR));
            step({t, ".mem"}, 0, 0, 1, 0, 0, mk(fld, 2'b00, k == K_LW ? MRD : MWR));
            if (k == K_SW) return;
        end
        ovq = ov && (a == 3'b001 || a == 3'b101);
        step({t, ".wb"}, 0, 0, 0, 0, 0, mk(fld, 2'b00, ovq ? OVT : RWR));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; imem_rdy = 0; dmem_rdy = 0; zero = 0; ovf = 0; op = '0; funct = '0;
        @(posedge clk); #1;
        step("reset0", 1, 1, 1, 1, 1, '0);
        step("reset1", 1, 1, 0, 0, 0, '0);

        run_instr("add_ovf",  6'b000000, 6'b100000, K_R, 3'b001, 0, 0, 1, 0, 0, 0, 1);
        run_instr("addu_ovf", 6'b000000, 6'b100001, K_R, 3'b000, 0, 0, 1, 0, 0, 0, 1);
        run_instr("lw_waits", 6'b100011, 6'b000000, K_LW, 3'b000, 1, 1, 0, 2, 3, 0, 0);
        run_instr("beq_t",    6'b000100, 6'b000000, K_BEQ, 3'b100, 0, 1, 0, 0, 0, 1, 0);
        run_instr("beq_nt",   6'b000100, 6'b000000, K_BEQ, 3'b100, 0, 1, 0, 0, 0, 0, 0);
        run_instr("ill_op",   6'b111111, 6'b100000, K_ILL, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        run_instr("ill_fn",   6'b000000, 6'b000000, K_ILL, 3'b000, 0, 0, 0, 1, 0, 0, 0);

        run_instr("addu",  6'b000000, 6'b100001, K_R, 3'b000, 0, 0, 1, 0, 0, 0, 0);
        run_instr("add",   6'b000000, 6'b100000, K_R, 3'b001, 0, 0, 1, 0, 0, 0, 0);
        run_instr("subu",  6'b000000, 6'b100011, K_R, 3'b100, 0, 0, 1, 0, 0, 0, 1);
        run_instr("sub",   6'b000000, 6'b100010, K_R, 3'b101, 0, 0, 1, 0, 0, 0, 1);
        run_instr("sltu",  6'b000000, 6'b101011, K_R, 3'b110, 0, 0, 1, 0, 0, 0, 0);
        run_instr("slt",   6'b000000, 6'b101010, K_R, 3'b111, 0, 0, 1, 0, 0, 0, 0);
        run_instr("or",    6'b000000, 6'b100101, K_R, 3'b010, 0, 0, 1, 0, 0, 0, 0);
        run_instr("ori",   6'b001101, 6'b000000, K_IMM, 3'b010, 1, 0, 0, 0, 0, 0, 1);
        run_instr("addiu", 6'b001001, 6'b000000, K_IMM, 3'b000, 1, 1, 0, 1, 0, 0, 0);
        run_instr("j",     6'b000010, 6'b000000, K_J, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        run_instr("sw",    6'b101011, 6'b000000, K_SW, 3'b000, 1, 1, 0, 0, 1, 0, 0);

        // sw stalled in MEM, then reset: strobes must drop immediately and fetch restarts
        op = 6'b101011; funct = '0;
        step("swrst.if",  0, 1, 0, 0, 0, mk('0, 2'b00, FETCH));
        step("swrst.id",  0, 0, 0, 0, 0, mk(7'b0001100, 2'b00, NONE));
        step("swrst.exe", 0, 0, 0, 0, 0, mk(7'b0001100, 2'b00, NONE));
        step("swrst.mem", 0, 0, 0, 0, 0, mk(7'b0001100, 2'b00, MWR));
        step("swrst.rst0", 1, 0, 0, 0, 0, '0);
        step("swrst.rst1", 1, 0, 0, 0, 0, '0);
        step("swrst.if_after", 0, 0, 0, 0, 0, mk('0, 2'b00, MRD));

        run_instr("lw",   6'b100011, 6'b000000, K_LW, 3'b000, 1, 1, 0, 0, 0, 0, 0);
        run_instr("addu2", 6'b000000, 6'b100001, K_R, 3'b000, 0, 0, 1, 0, 0, 1, 1);

        @(negedge clk); #1;
        check_val("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
